muxw_n1_rr: RTL and testbench

Registered N-channel, W-bit selector with valid/ready handshakes on every input and on the output, for the datapath forwarding and writeback select points. Successor to the combinational 2-bit N:1 selector: width is parametrised, the output is registered with back-pressure, and a round-robin mode lets the block pick among valid channels by itself. One slice is granted and transferred per cycle.

---
 rtl/muxw_n1_rr.sv | 107 ++++++++++
 tb/tb_muxw_n1_rr.sv | 177 +++++++++++++++++
 2 files changed

// File: rtl/muxw_n1_rr.sv
// Registered N:1 W-bit selector with valid/ready on every channel and on the output.
// Round-robin mode and its pointer are compiled in only when MUXW_N1_RR_EN is defined.
module muxw_n1_rr #(
    parameter int W = 32,
    parameter int N = 4
) (
    input  logic                 Clk,
    input  logic                 Rst,
    input  logic [W*N-1:0]       Vin,
    input  logic [N-1:0]         VinValid,
    output logic [N-1:0]         VinReady,
    input  logic [$clog2(N)-1:0] Sel,
    input  logic                 Mode,
    output logic [W-1:0]         Vout,
    output logic                 VoutValid,
    input  logic                 VoutReady,
    output logic [$clog2(N)-1:0] VoutSel
);
    localparam int SW = $clog2(N);

    // Handshake: a channel word moves when VinValid[g] & VinReady[g] at a rising Clk;
    // the output word moves downstream when VoutValid & VoutReady at a rising Clk.

    logic [W-1:0]  ch [N];
    logic          load;
    logic          grant_valid;
    logic [SW-1:0] grant_idx;
    logic          xfer;

    always_comb begin
        for (int i = 0; i < N; i++) begin
            ch[i] = Vin[i*W +: W];
        end
    end

    assign load = ~VoutValid | VoutReady;

`ifdef MUXW_N1_RR_EN
    logic [SW-1:0] ptr;
    logic [SW-1:0] cand;

    always_comb begin
        grant_valid = 1'b0;
        grant_idx   = '0;
        cand        = '0;
        if (Mode) begin
            // Search starts at ptr and wraps; first valid channel wins.
            for (int i = 0; i < N; i++) begin
                cand = SW'((int'(ptr) + i) % N);
                if (!grant_valid && VinValid[cand]) begin
                    grant_valid = 1'b1;
                    grant_idx   = cand;
                end
            end
        end else if (int'(Sel) < N) begin
            grant_valid = 1'b1;
            grant_idx   = Sel;
        end
    end

    always_ff @(posedge Clk or posedge Rst) begin
        if (Rst) begin
            ptr <= '0;
        end else if (Mode && xfer) begin
            ptr <= (int'(grant_idx) == N - 1) ? '0 : grant_idx + 1'b1;
        end
    end
`else
    logic unused_mode;
    assign unused_mode = Mode;

    always_comb begin
        grant_valid = 1'b0;
        grant_idx   = '0;
        if (int'(Sel) < N) begin
            grant_valid = 1'b1;
            grant_idx   = Sel;
        end
    end
`endif

    always_comb begin
        VinReady = '0;
        if (!Rst && grant_valid && load) begin
            VinReady[grant_idx] = 1'b1;
        end
    end

    assign xfer = grant_valid & load & VinValid[grant_idx] & ~Rst;

    always_ff @(posedge Clk or posedge Rst) begin
        if (Rst) begin
            Vout      <= '0;
            VoutValid <= 1'b0;
            VoutSel   <= '0;
        end else if (load) begin
            // With no transfer the word drains; data and index are kept for observation.
            if (xfer) begin
                Vout      <= ch[grant_idx];
                VoutSel   <= grant_idx;
                VoutValid <= 1'b1;
            end else begin
                VoutValid <= 1'b0;
            end
        end
    end
endmodule

// File: tb/tb_muxw_n1_rr.sv
// Directed bench for muxw_n1_rr: W=8 with N=4 (main) and N=3 (out-of-range select).
// Round-robin checks are built when MUXW_N1_RR_EN is defined, fixed-only checks otherwise.
module tb_muxw_n1_rr;
    localparam int W = 8;

    logic        clk = 1'b0;
    logic        rst;
    // N=4 instance
    logic [31:0] vin;
    logic [3:0]  vin_valid;
    logic [3:0]  vin_ready;
    logic [1:0]  sel;
    logic        mode;
    logic [7:0]  vout;
    logic        vout_valid;
    logic        vout_ready;
    logic [1:0]  vout_sel;
    // N=3 instance
    logic [23:0] vin3;
    logic [2:0]  vin_valid3;
    logic [2:0]  vin_ready3;
    logic [1:0]  sel3;
    logic [7:0]  vout3;
    logic        vout_valid3;
    logic        vout_ready3;
    logic [1:0]  vout_sel3;

    int n_cmp  = 0;
    int n_fail = 0;

    muxw_n1_rr #(.W(W), .N(4)) dut (
        .Clk(clk), .Rst(rst), .Vin(vin), .VinValid(vin_valid), .VinReady(vin_ready),
        .Sel(sel), .Mode(mode), .Vout(vout), .VoutValid(vout_valid),
        .VoutReady(vout_ready), .VoutSel(vout_sel)
    );

    muxw_n1_rr #(.W(W), .N(3)) dut3 (
        .Clk(clk), .Rst(rst), .Vin(vin3), .VinValid(vin_valid3), .VinReady(vin_ready3),
        .Sel(sel3), .Mode(1'b0), .Vout(vout3), .VoutValid(vout_valid3),
        .VoutReady(vout_ready3), .VoutSel(vout_sel3)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [1:0]  sel;
        logic [3:0]  vv;
        logic        vr;
        logic [31:0] vin;
        logic [3:0]  exp_ready;
        logic        exp_valid;
        logic [7:0]  exp_vout;
        logic [1:0]  exp_sel;
    } vec_t;

    vec_t tbl [10];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Starts at posedge+1: drive inputs, check ready, clock, check registered outputs.
    task automatic cyc(input string name, input logic [1:0] s, input logic m, input logic [3:0] vv,
                       input logic vr, input logic [31:0] d, input logic [3:0] e_rdy,
                       input logic e_val, input logic [7:0] e_out, input logic [1:0] e_sel);
        sel = s; mode = m; vin_valid = vv; vout_ready = vr; vin = d;
        #1;
        check({name, ".ready"}, 32'(vin_ready), 32'(e_rdy));
        @(posedge clk); #1;
        check({name, ".valid"}, 32'(vout_valid), 32'(e_val));
        if (e_val) begin
            check({name, ".vout"}, 32'(vout), 32'(e_out));
            check({name, ".sel"}, 32'(vout_sel), 32'(e_sel));
        end
    endtask

    task automatic do_reset();
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
    endtask

    initial begin
        tbl[0] = '{2'd2, 4'b0100, 1'b1, 32'h44A52211, 4'b0100, 1'b1, 8'hA5, 2'd2};
        tbl[1] = '{2'd2, 4'b0100, 1'b0, 32'h44B62211, 4'b0000, 1'b1, 8'hA5, 2'd2};
        tbl[2] = '{2'd2, 4'b0100, 1'b0, 32'h44B62211, 4'b0000, 1'b1, 8'hA5, 2'd2};
        tbl[3] = '{2'd2, 4'b0100, 1'b0, 32'h44B62211, 4'b0000, 1'b1, 8'hA5, 2'd2};
        tbl[4] = '{2'd2, 4'b0100, 1'b1, 32'h44B62211, 4'b0100, 1'b1, 8'hB6, 2'd2};
        tbl[5] = '{2'd0, 4'b0001, 1'b1, 32'h44B62277, 4'b0001, 1'b1, 8'h77, 2'd0};
        tbl[6] = '{2'd1, 4'b0000, 1'b1, 32'h44B62277, 4'b0010, 1'b0, 8'h77, 2'd0};
        tbl[7] = '{2'd3, 4'b1000, 1'b0, 32'hC8B62277, 4'b1000, 1'b1, 8'hC8, 2'd3};
        tbl[8] = '{2'd3, 4'b1000, 1'b0, 32'hD9B62277, 4'b0000, 1'b1, 8'hC8, 2'd3};
        tbl[9] = '{2'd1, 4'b0010, 1'b1, 32'h44B6E177, 4'b0010, 1'b1, 8'hE1, 2'd1};

        rst = 1'b1; vin = '0; vin_valid = '0; sel = '0; mode = 1'b0; vout_ready = 1'b1;
        vin3 = '0; vin_valid3 = '0; sel3 = '0; vout_ready3 = 1'b1;
        @(posedge clk); #1;
        sel = 2'd2; vin_valid = 4'b0100;
        #1;
        check("rst_state.valid", 32'(vout_valid), 32'd0);
        check("rst_state.vout", 32'(vout), 32'd0);
        check("rst_state.sel", 32'(vout_sel), 32'd0);
        check("rst_state.ready", 32'(vin_ready), 32'd0);
        @(posedge clk); #1;
        rst = 1'b0;

        // Fixed mode: load, 3-cycle stall, bubble-free release, drain, out-of-stall reloads
        for (int i = 0; i < 10; i++) begin
            cyc($sformatf("fixed[%0d]", i), tbl[i].sel, 1'b0, tbl[i].vv, tbl[i].vr, tbl[i].vin,
                tbl[i].exp_ready, tbl[i].exp_valid, tbl[i].exp_vout, tbl[i].exp_sel);
        end

        // Reset mid-stream with a held word, then first transfer on the edge after release
        sel = 2'd1; vin_valid = 4'b0010; vout_ready = 1'b0;
        #2;
        rst = 1'b1;
        #1;
        check("midrst.valid", 32'(vout_valid), 32'd0);
        check("midrst.vout", 32'(vout), 32'd0);
        check("midrst.sel", 32'(vout_sel), 32'd0);
        check("midrst.ready", 32'(vin_ready), 32'd0);
        @(posedge clk); #1;
        rst = 1'b0;
        cyc("post_rst", 2'd2, 1'b0, 4'b0100, 1'b1, 32'h445A2211, 4'b0100, 1'b1, 8'h5A, 2'd2);

`ifdef MUXW_N1_RR_EN
        do_reset();
        cyc("rr0", 2'd0, 1'b1, 4'b1111, 1'b1, 32'h44332211, 4'b0001, 1'b1, 8'h11, 2'd0);
        cyc("rr1", 2'd0, 1'b1, 4'b1111, 1'b1, 32'h44332211, 4'b0010, 1'b1, 8'h22, 2'd1);
        cyc("rr2", 2'd0, 1'b1, 4'b1111, 1'b1, 32'h44332211, 4'b0100, 1'b1, 8'h33, 2'd2);
        cyc("rr3", 2'd0, 1'b1, 4'b1111, 1'b1, 32'h44332211, 4'b1000, 1'b1, 8'h44, 2'd3);
        cyc("rr4", 2'd0, 1'b1, 4'b1111, 1'b1, 32'h44332211, 4'b0001, 1'b1, 8'h11, 2'd0);
        cyc("rr5", 2'd0, 1'b1, 4'b1111, 1'b1, 32'h44332211, 4'b0010, 1'b1, 8'h22, 2'd1);
        // Ptr=2 with only ch1/ch3 valid
        cyc("rr13a", 2'd0, 1'b1, 4'b1010, 1'b1, 32'h44332211, 4'b1000, 1'b1, 8'h44, 2'd3);
        cyc("rr13b", 2'd0, 1'b1, 4'b1010, 1'b1, 32'h44332211, 4'b0010, 1'b1, 8'h22, 2'd1);
        cyc("rr13c", 2'd0, 1'b1, 4'b1010, 1'b1, 32'h44332211, 4'b1000, 1'b1, 8'h44, 2'd3);
        // No valid channel for 2 cycles: drain, then Ptr still 0
        cyc("rr_none0", 2'd2, 1'b1, 4'b0000, 1'b1, 32'h44332211, 4'b0000, 1'b0, 8'h44, 2'd3);
        cyc("rr_none1", 2'd2, 1'b1, 4'b0000, 1'b1, 32'h44332211, 4'b0000, 1'b0, 8'h44, 2'd3);
        check("rr_none.vout_hold", 32'(vout), 32'h44);
        cyc("rr_ptr_kept", 2'd2, 1'b1, 4'b1111, 1'b1, 32'h44332211, 4'b0001, 1'b1, 8'h11, 2'd0);
        // Stall in round-robin, then back to fixed mode on the fly
        cyc("rr_stall", 2'd2, 1'b1, 4'b1111, 1'b0, 32'h44332211, 4'b0000, 1'b1, 8'h11, 2'd0);
        cyc("rr_to_fixed", 2'd3, 1'b0, 4'b1111, 1'b1, 32'h44332211, 4'b1000, 1'b1, 8'h44, 2'd3);
`else
        cyc("nomacro_a", 2'd1, 1'b1, 4'b1111, 1'b1, 32'h44332211, 4'b0010, 1'b1, 8'h22, 2'd1);
        cyc("nomacro_b", 2'd1, 1'b1, 4'b1111, 1'b1, 32'h44332299, 4'b0010, 1'b1, 8'h22, 2'd1);
        cyc("nomacro_c", 2'd1, 1'b1, 4'b0001, 1'b1, 32'h44332211, 4'b0010, 1'b0, 8'h22, 2'd1);
`endif

        // N=3: Sel=3 is out of range, no grant, pending word drains
        sel3 = 2'd0; vin_valid3 = 3'b001; vin3 = 24'h332211; vout_ready3 = 1'b1;
        @(posedge clk); #1;
        check("n3_load.valid", 32'(vout_valid3), 32'd1);
        check("n3_load.vout", 32'(vout3), 32'h11);
        sel3 = 2'd3; vin_valid3 = 3'b111;
        #1;
        check("n3_oor.ready", 32'(vin_ready3), 32'd0);
        @(posedge clk); #1;
        check("n3_oor.valid", 32'(vout_valid3), 32'd0);
        check("n3_oor.vout_hold", 32'(vout3), 32'h11);
        sel3 = 2'd2;
        #1;
        check("n3_sel2.ready", 32'(vin_ready3), 32'b100);
        @(posedge clk); #1;
        check("n3_sel2.vout", 32'(vout3), 32'h33);
        check("n3_sel2.sel", 32'(vout_sel3), 32'd2);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end
endmodule
